camera_capture_ctrl: RTL and testbench

Sequences single-frame and continuous capture from the 12-bit camera pixel bus into a pixel buffer. It has a 4-register memory-mapped control slave on the Nios system bus, so software can arm captures, poll status and read counts. It gates pixels by frame and line valid, generates buffer write addresses, and detects overflow and drops. It raises an interrupt at end of frame. Camera signals arrive already synchronised to clk.

---
 rtl/camera_capture_ctrl_if.sv | 32 +++
 rtl/camera_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_camera_capture_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_capture_ctrl_if.sv
// Bus bundle for camera_capture_ctrl: register slave, camera pixel input and buffer write port.
interface camera_capture_ctrl_if #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned ADDR_W = 19
);
   logic [1:0]        address;
   logic              write;
   logic [31:0]       writedata;
   logic              read;
   logic [31:0]       readdata;
   logic              frame_valid;
   logic              line_valid;
   logic              pix_valid;
   logic [DATA_W-1:0] pix_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              irq;

   modport slave (
      input  address, write, writedata, read,
      input  frame_valid, line_valid, pix_valid, pix_data, wr_ready,
      output readdata, wr_en, wr_addr, wr_data, irq
   );

   modport master (
      output address, write, writedata, read,
      output frame_valid, line_valid, pix_valid, pix_data, wr_ready,
      input  readdata, wr_en, wr_addr, wr_data, irq
   );
endinterface

// File: rtl/camera_capture_ctrl.sv
// Single-shot / continuous frame capture from the camera pixel bus into a pixel buffer,
// with a 4-register control slave and an end-of-frame interrupt.
module camera_capture_ctrl #(
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned MAX_PIXELS = 307200
) (
   input  logic                  clk,
   input  logic                  reset,
   camera_capture_ctrl_if.slave  bus
);

   // One extra bit so a full buffer of 2^ADDR_W pixels is representable.
   localparam int unsigned      CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PIXELS);

   typedef enum logic [1:0] {IDLE, ARM, WAIT_SOF, CAPTURE} state_t;

   state_t           state, state_nxt;
   logic             fv_q;
   logic             cont, irq_en, done, ovf, drop;
   logic [CNT_W-1:0] pixcnt;
   logic [15:0]      framecnt;

   logic        ctrl_wr_c, stat_wr_c, start_c, abort_c, sof_c, eof_c;
   logic        cap_c, pix_c, full_c, accept_c, drop_set_c, ovf_set_c;
   logic        frame_end_c, clr_cnt_c;
   logic        cont_n, irq_en_n, done_n, ovf_n, drop_n;
   logic [31:0] rd_mux_c;
   logic        unused_c;

   assign ctrl_wr_c = bus.write && (bus.address == 2'd0);
   assign stat_wr_c = bus.write && (bus.address == 2'd1);
   assign start_c   = ctrl_wr_c && bus.writedata[0];
   assign abort_c   = ctrl_wr_c && bus.writedata[3];
   assign sof_c     = bus.frame_valid && !fv_q;
   assign eof_c     = !bus.frame_valid && fv_q;
   assign unused_c  = ^{bus.read, bus.writedata[31:4]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; ARM holds off until the camera is between frames
   always_comb begin
      state_nxt = state;
      if (abort_c) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:     if (start_c)           state_nxt = ARM;
            ARM:      if (!bus.frame_valid)  state_nxt = WAIT_SOF;
            WAIT_SOF: if (sof_c)             state_nxt = CAPTURE;
            CAPTURE:  if (eof_c)             state_nxt = cont ? WAIT_SOF : IDLE;
            default:                         state_nxt = IDLE;
         endcase
      end
   end

   // Per-cycle control strobes, register next values and read mux
   always_comb begin
      cap_c       = 1'b0;
      pix_c       = 1'b0;
      full_c      = 1'b0;
      accept_c    = 1'b0;
      drop_set_c  = 1'b0;
      ovf_set_c   = 1'b0;
      frame_end_c = 1'b0;
      clr_cnt_c   = 1'b0;
      cont_n      = cont;
      irq_en_n    = irq_en;
      done_n      = done;
      ovf_n       = ovf;
      drop_n      = drop;
      rd_mux_c    = 32'd0;

      cap_c       = (state == CAPTURE) && !abort_c;
      pix_c       = bus.frame_valid && bus.line_valid && bus.pix_valid;
      full_c      = (pixcnt >= MAX_CNT);
      accept_c    = cap_c && pix_c && bus.wr_ready && !full_c;
      drop_set_c  = cap_c && pix_c && !bus.wr_ready;
      ovf_set_c   = cap_c && pix_c && full_c;
      frame_end_c = cap_c && eof_c;
      clr_cnt_c   = !abort_c && ((state == ARM) || (frame_end_c && cont));

      if (ctrl_wr_c) begin
         cont_n   = bus.writedata[1];
         irq_en_n = bus.writedata[2];
      end
      // Hardware set takes priority over a same-cycle write-one-to-clear
      done_n = frame_end_c || (done && !(stat_wr_c && bus.writedata[1]));
      ovf_n  = ovf_set_c   || (ovf  && !(stat_wr_c && bus.writedata[2]));
      drop_n = drop_set_c  || (drop && !(stat_wr_c && bus.writedata[3]));

      case (bus.address)
         2'd0:    rd_mux_c = {29'd0, irq_en, cont, 1'b0};
         2'd1:    rd_mux_c = {28'd0, drop, ovf, done, (state != IDLE)};
         2'd2:    rd_mux_c = 32'(pixcnt);
         default: rd_mux_c = {16'd0, framecnt};
      endcase
   end

   // Registers, write pipeline and outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fv_q         <= 1'b0;
         cont         <= 1'b0;
         irq_en       <= 1'b0;
         done         <= 1'b0;
         ovf          <= 1'b0;
         drop         <= 1'b0;
         pixcnt       <= '0;
         framecnt     <= 16'd0;
         bus.readdata <= 32'd0;
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= '0;
         bus.wr_data  <= '0;
         bus.irq      <= 1'b0;
      end else begin
         fv_q         <= bus.frame_valid;
         cont         <= cont_n;
         irq_en       <= irq_en_n;
         done         <= done_n;
         ovf          <= ovf_n;
         drop         <= drop_n;
         bus.readdata <= rd_mux_c;
         bus.wr_en    <= accept_c;
         bus.irq      <= irq_en_n && done_n;
         if (accept_c) begin
            bus.wr_addr <= ADDR_W'(pixcnt);
            bus.wr_data <= bus.pix_data;
            pixcnt      <= pixcnt + CNT_W'(1);
         end else if (clr_cnt_c) begin
            bus.wr_addr <= '0;
            pixcnt      <= '0;
         end
         if (frame_end_c) framecnt <= framecnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Bench for camera_capture_ctrl: two instances (full-size and 16-pixel buffer) share one stimulus stream.
module tb_camera_capture_ctrl;

   localparam int unsigned DATA_W = 12;
   localparam int unsigned ADDR_W = 19;
   localparam int          MAX_A  = 307200;
   localparam int          MAX_B  = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]        s_address;
   logic              s_write, s_read;
   logic [31:0]       s_writedata;
   logic              s_fv, s_lv, s_pv, s_rdy;
   logic [DATA_W-1:0] s_data;

   camera_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifa ();
   camera_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifb ();

   assign ifa.address = s_address;    assign ifb.address = s_address;
   assign ifa.write = s_write;        assign ifb.write = s_write;
   assign ifa.writedata = s_writedata; assign ifb.writedata = s_writedata;
   assign ifa.read = s_read;          assign ifb.read = s_read;
   assign ifa.frame_valid = s_fv;     assign ifb.frame_valid = s_fv;
   assign ifa.line_valid = s_lv;      assign ifb.line_valid = s_lv;
   assign ifa.pix_valid = s_pv;       assign ifb.pix_valid = s_pv;
   assign ifa.pix_data = s_data;      assign ifb.pix_data = s_data;
   assign ifa.wr_ready = s_rdy;       assign ifb.wr_ready = s_rdy;

   camera_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PIXELS(MAX_A))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   camera_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PIXELS(MAX_B))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   wr_t         qa[$], qb[$];
   logic [31:0] rqa[$], rqb[$];
   int          rqaddr[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   // Expected-state model of the register file
   int cnt_a, cnt_b, e_frames;
   bit e_busy, e_armed, e_cap, e_cont, e_irqen, e_done, e_ovf_a, e_ovf_b, e_drop;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops expected writes / read data whenever the DUTs present them
   logic rd_seen;
   wr_t  ea, eb;
   int   ra;
   always @(posedge clk or posedge reset) begin
      if (reset) rd_seen <= 1'b0;
      else       rd_seen <= s_read;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (ifa.wr_en) begin
            if (qa.size() == 0) check("wr_a_unexpected", 32'd1, 32'd0);
            else begin
               ea = qa.pop_front();
               check("wr_a_addr", 32'(ifa.wr_addr), 32'(ea.addr));
               check("wr_a_data", 32'(ifa.wr_data), 32'(ea.data));
            end
         end
         if (ifb.wr_en) begin
            if (qb.size() == 0) check("wr_b_unexpected", 32'd1, 32'd0);
            else begin
               eb = qb.pop_front();
               check("wr_b_addr", 32'(ifb.wr_addr), 32'(eb.addr));
               check("wr_b_data", 32'(ifb.wr_data), 32'(eb.data));
            end
         end
         if (rd_seen && rqaddr.size() != 0) begin
            ra = rqaddr.pop_front();
            check($sformatf("rd_a_reg%0d", ra), ifa.readdata, rqa.pop_front());
            check($sformatf("rd_b_reg%0d", ra), ifb.readdata, rqb.pop_front());
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] exp_reg(int a, bit is_b);
      case (a)
         0:       return {29'd0, e_irqen, e_cont, 1'b0};
         1:       return {28'd0, e_drop, (is_b ? e_ovf_b : e_ovf_a), e_done, e_busy};
         2:       return 32'(is_b ? cnt_b : cnt_a);
         default: return 32'(e_frames % 65536);
      endcase
   endfunction

   task automatic read_all();
      for (int a = 0; a < 4; a++) begin
         s_address = 2'(a);
         s_read    = 1'b1;
         rqaddr.push_back(a);
         rqa.push_back(exp_reg(a, 1'b0));
         rqb.push_back(exp_reg(a, 1'b1));
         tick();
      end
      s_read = 1'b0;
      tick(2);
   endtask

   task automatic check_irq(string tag);
      check({"irq_a_", tag}, 32'(ifa.irq), 32'(e_irqen & e_done));
      check({"irq_b_", tag}, 32'(ifb.irq), 32'(e_irqen & e_done));
   endtask

   function automatic void ctrl_model(logic [31:0] v);
      e_cont  = v[1];
      e_irqen = v[2];
      if (v[3]) begin
         e_busy = 0; e_armed = 0; e_cap = 0;
      end else if (v[0] && !e_busy) begin
         e_busy = 1; e_armed = 1; cnt_a = 0; cnt_b = 0;
      end
   endfunction

   task automatic reg_write(int a, logic [31:0] v);
      s_address   = 2'(a);
      s_writedata = v;
      s_write     = 1'b1;
      if (a == 0) ctrl_model(v);
      else if (a == 1) begin
         if (v[1]) e_done = 0;
         if (v[2]) begin e_ovf_a = 0; e_ovf_b = 0; end
         if (v[3]) e_drop = 0;
      end
      tick();
      s_write = 1'b0;
      tick();
   endtask

   // One frame; optional wr_ready-low window and a CTRL write landing on pixel ctl_at
   task automatic frame(int lines, int ppl, int base, int drop_lo, int drop_hi,
                        int ctl_at, logic [31:0] ctl_val);
      int  idx;
      bit  rdy;
      wr_t w;
      idx = 0;
      if (e_armed) begin e_cap = 1; e_armed = 0; end
      s_fv = 1'b1; s_lv = 1'b0; s_pv = 1'b0;
      tick(2);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            rdy    = !(idx >= drop_lo && idx <= drop_hi);
            s_lv   = 1'b1; s_pv = 1'b1; s_rdy = rdy;
            s_data = DATA_W'(base + idx);
            if (idx == ctl_at) begin
               s_address = 2'd0; s_writedata = ctl_val; s_write = 1'b1;
               ctrl_model(ctl_val);
            end
            if (e_cap) begin
               if (!rdy) e_drop = 1;
               if (cnt_a >= MAX_A) e_ovf_a = 1;
               else if (rdy) begin
                  w.addr = ADDR_W'(cnt_a); w.data = DATA_W'(base + idx);
                  qa.push_back(w); cnt_a++;
               end
               if (cnt_b >= MAX_B) e_ovf_b = 1;
               else if (rdy) begin
                  w.addr = ADDR_W'(cnt_b); w.data = DATA_W'(base + idx);
                  qb.push_back(w); cnt_b++;
               end
            end
            tick();
            s_write = 1'b0;
            s_rdy   = 1'b1;
            idx++;
         end
         s_lv = 1'b0; s_pv = 1'b0;
         tick(2);
      end
      s_fv = 1'b0;
      if (e_cap) begin
         e_done = 1;
         e_frames++;
         if (e_cont) begin e_armed = 1; cnt_a = 0; cnt_b = 0; end
         else e_busy = 0;
         e_cap = 0;
      end
      tick(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      s_address = 2'd0; s_write = 1'b0; s_read = 1'b0; s_writedata = 32'd0;
      s_fv = 1'b0; s_lv = 1'b0; s_pv = 1'b0; s_rdy = 1'b1; s_data = '0;
      cnt_a = 0; cnt_b = 0; e_frames = 0;
      e_busy = 0; e_armed = 0; e_cap = 0; e_cont = 0; e_irqen = 0;
      e_done = 0; e_ovf_a = 0; e_ovf_b = 0; e_drop = 0;
      tick(3);
      check("rst_wr_en", 32'(ifa.wr_en), 32'd0);
      check("rst_irq", 32'(ifa.irq), 32'd0);
      check("rst_readdata", ifb.readdata, 32'd0);
      reset = 1'b0;
      tick(2);
      read_all();
      check_irq("reset");

      // Single frame 4x8 armed with frame_valid low; small buffer overflows at 16
      reg_write(0, 32'h1);
      tick(3);
      frame(4, 8, 'h100, -1, -1, -1, 32'h0);
      read_all();
      check_irq("irqen0");
      reg_write(0, 32'h4);
      check_irq("irqen1");
      reg_write(1, 32'h4);
      read_all();
      reg_write(1, 32'hE);
      check_irq("cleared");

      // START mid-frame: that frame skipped, next one captured from address 0
      frame(3, 4, 'h300, -1, -1, 5, 32'h5);
      frame(2, 4, 'h200, -1, -1, -1, 32'h0);
      read_all();
      check_irq("midstart");
      reg_write(1, 32'hE);

      // 20-pixel frame: 16-pixel instance overflows, then W1C of OVERFLOW
      reg_write(0, 32'h1);
      tick(3);
      frame(4, 5, 'h400, -1, -1, -1, 32'h0);
      read_all();
      reg_write(1, 32'h4);
      read_all();
      reg_write(1, 32'hE);

      // wr_ready low for pixels 5..7 mid-line: DROP, addresses stay contiguous
      reg_write(0, 32'h1);
      tick(3);
      frame(2, 8, 'h500, 5, 7, -1, 32'h0);
      read_all();
      reg_write(1, 32'hE);

      // Continuous mode across 3 frames, then ABORT mid-frame
      reg_write(0, 32'h3);
      tick(3);
      frame(2, 4, 'h600, -1, -1, -1, 32'h0);
      frame(2, 4, 'h610, -1, -1, -1, 32'h0);
      frame(2, 4, 'h620, -1, -1, -1, 32'h0);
      read_all();
      frame(2, 4, 'h630, -1, -1, 3, 32'h8);
      read_all();
      check_irq("abort");

      tick(4);
      check("qa_empty", 32'(qa.size()), 32'd0);
      check("qb_empty", 32'(qb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
